// File: rtl/data_memory_pkg.sv
// Shared widths, func3 access codes and the store lane helper for the RV32I data memory.
package data_memory_pkg;

    localparam int AddrWidth  = 32;
    localparam int DataWidth  = 32;
    localparam int Func3Width = 3;

    typedef enum logic [Func3Width-1:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } func3_e;

    // Byte lanes (relative to the access index) touched by a store of the given width.
    function automatic logic [3:0] store_lanes(input logic [Func3Width-1:0] f3);
        logic [3:0] lanes;
        case (f3)
            F3_B:    lanes = 4'b0001;
            F3_H:    lanes = 4'b0011;
            F3_W:    lanes = 4'b1111;
            default: lanes = 4'b0000;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/data_memory_load_extend.sv
// Combinational load formatter: selects width and sign/zero extension of a raw little-endian word.
module data_memory_load_extend
    import data_memory_pkg::*;
(
    input  logic [Func3Width-1:0] func3_i,
    input  logic [DataWidth-1:0]  raw_i,
    output logic [DataWidth-1:0]  result_o
);

    // Width/sign decode; reserved codes read as zero.
    always_comb begin
        result_o = '0;
        case (func3_i)
            F3_B:    result_o = {{24{raw_i[7]}}, raw_i[7:0]};
            F3_H:    result_o = {{16{raw_i[15]}}, raw_i[15:0]};
            F3_W:    result_o = raw_i;
            F3_BU:   result_o = {24'h000000, raw_i[7:0]};
            F3_HU:   result_o = {16'h0000, raw_i[15:0]};
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Byte-addressed little-endian data memory: combinational loads, clocked stores, wrapping indices.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_BYTES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] memAddr,
    output logic [DATA_WIDTH-1:0] memReadData,
    input  logic                  memWriteEnable,
    input  logic [DATA_WIDTH-1:0] memWriteData,
    input  logic [ADDR_WIDTH-1:0] PC,
    input  logic [2:0]            func3
);

    localparam int IdxW = $clog2(DEPTH_BYTES);

    logic [7:0]      mem_q [DEPTH_BYTES];
    logic [IdxW-1:0] idx_s [4];
    logic [3:0]      lane_en_s;
    logic [31:0]     raw_s;
    logic [31:0]     load_s;
    logic            unused_s;

    // Lane indices wrap naturally because they are only IdxW bits wide.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            idx_s[k] = memAddr[IdxW-1:0] + IdxW'(k);
        end
    end

    // Per-lane write enables for the current store.
    always_comb begin
        if (memWriteEnable) begin
            lane_en_s = store_lanes(func3);
        end else begin
            lane_en_s = 4'b0000;
        end
    end

    // Storage: async clear on reset, byte-lane writes on the rising edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH_BYTES; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (lane_en_s[k]) begin
                    mem_q[idx_s[k]] <= memWriteData[8*k +: 8];
                end
            end
        end
    end

    assign raw_s = {mem_q[idx_s[3]], mem_q[idx_s[2]], mem_q[idx_s[1]], mem_q[idx_s[0]]};

    data_memory_load_extend u_load_extend (
        .func3_i  (func3),
        .raw_i    (raw_s),
        .result_o (load_s)
    );

    assign memReadData = DATA_WIDTH'(load_s);

    // PC is trace-only and the upper address bits alias; both are intentionally unused.
    assign unused_s = ^{PC, memAddr[ADDR_WIDTH-1:IdxW]};

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: directed test-plan cases plus randomized traffic vs a byte-array model.
module tb_data_memory;
    import data_memory_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] memAddr = 32'h0;
    logic [31:0] memReadData;
    logic        memWriteEnable = 1'b0;
    logic [31:0] memWriteData = 32'h0;
    logic [31:0] PC = 32'h0;
    logic [2:0]  func3 = 3'b000;

    data_memory dut (
        .clk            (clk),
        .reset          (reset),
        .memAddr        (memAddr),
        .memReadData    (memReadData),
        .memWriteEnable (memWriteEnable),
        .memWriteData   (memWriteData),
        .PC             (PC),
        .func3          (func3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    logic        rd_req = 1'b0;
    logic [7:0]  model [1024];

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic [2:0] f);
        int         base;
        logic [7:0] b0, b1, b2, b3;
        base = int'(a % 32'd1024);
        b0 = model[base];
        b1 = model[(base + 1) % 1024];
        b2 = model[(base + 2) % 1024];
        b3 = model[(base + 3) % 1024];
        case (f)
            3'b000:  return 32'($signed(b0));
            3'b001:  return 32'($signed({b1, b0}));
            3'b010:  return {b3, b2, b1, b0};
            3'b100:  return 32'(b0);
            3'b101:  return 32'({b1, b0});
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        int n;
        int base;
        n = (f == 3'b000) ? 1 : (f == 3'b001) ? 2 : (f == 3'b010) ? 4 : 0;
        base = int'(a % 32'd1024);
        for (int i = 0; i < n; i++) begin
            model[(base + i) % 1024] = d[8*i +: 8];
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 1024; i++) model[i] = 8'h00;
    endtask

    task automatic issue(input logic [31:0] exp, input string name);
        sb_q.push_back('{exp, name});
        rd_req = 1'b1;
        @(negedge clk);
        #1 rd_req = 1'b0;
    endtask

    // Read; expectation is the given constant, or the model when use_model is set.
    task automatic do_read(input logic [31:0] a, input logic [2:0] f, input logic [31:0] exp,
                           input bit use_model, input string name);
        @(posedge clk);
        #1;
        memWriteEnable = 1'b0;
        memAddr = a;
        func3 = f;
        PC = $urandom();
        issue(use_model ? model_read(a, f) : exp, name);
    endtask

    // Store; the same-cycle read must still show the pre-edge contents.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                            input logic en, input string name);
        @(posedge clk);
        #1;
        memWriteEnable = en;
        memAddr = a;
        memWriteData = d;
        func3 = f;
        PC = $urandom();
        issue(model_read(a, f), name);
        if (en) model_write(a, d, f);
    endtask

    // Reset pulsed between edges; the read must clear before any clock edge.
    task automatic do_reset_read(input logic [31:0] a, input string name);
        @(posedge clk);
        #1;
        memWriteEnable = 1'b0;
        reset = 1'b0;
        memAddr = a;
        func3 = F3_W;
        model_clear();
        issue(32'h0, name);
        reset = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rd_req) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow: read presented with no expectation queued");
            end else begin
                mon_e = sb_q.pop_front();
                if (memReadData !== mon_e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h (addr %h func3 %b)",
                             mon_e.name, memReadData, mon_e.exp, memAddr, func3);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rd, rhi;
        logic [2:0]  rf;
        model_clear();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        do_read(32'h0,   F3_W, 32'h0, 1'b0, "rst_lw_0");
        do_read(32'h3FC, F3_W, 32'h0, 1'b0, "rst_lw_3fc");

        do_write(32'h10, 32'hDEADBEEF, F3_W, 1'b1, "sw_old_data");
        do_read(32'h10, F3_W,  32'hDEADBEEF, 1'b0, "lw_10");
        do_read(32'h10, F3_B,  32'hFFFFFFEF, 1'b0, "lb_10");
        do_read(32'h13, F3_BU, 32'h000000DE, 1'b0, "lbu_13");
        do_read(32'h12, F3_H,  32'hFFFFDEAD, 1'b0, "lh_12");
        do_read(32'h10, F3_HU, 32'h0000BEEF, 1'b0, "lhu_10");

        do_write(32'h20, 32'h00000000, F3_W, 1'b1, "sw_20");
        do_write(32'h21, 32'hFFFFFF5A, F3_B, 1'b1, "sb_21");
        do_write(32'h22, 32'hABCD1234, F3_H, 1'b1, "sh_22");
        do_read(32'h20, F3_W, 32'h12345A00, 1'b0, "partial_lw_20");
        do_read(32'h24, F3_W, 32'h00000000, 1'b0, "adjacent_lw_24");

        do_write(32'h30, 32'hFFFFFFFF, F3_W, 1'b0, "sw_disabled");
        do_read(32'h30, F3_W, 32'h0, 1'b0, "gated_we0");
        do_write(32'h34, 32'hFFFFFFFF, 3'b011, 1'b1, "sw_f3_011");
        do_read(32'h34, F3_W, 32'h0, 1'b0, "gated_f3_011");
        do_read(32'h10, 3'b110, 32'h0, 1'b0, "ld_f3_110");

        do_write(32'h3FE, 32'hA1B2C3D4, F3_W, 1'b1, "sw_wrap");
        do_read(32'h3FE, F3_BU, 32'h000000D4, 1'b0, "wrap_b3fe");
        do_read(32'h3FF, F3_BU, 32'h000000C3, 1'b0, "wrap_b3ff");
        do_read(32'h000, F3_BU, 32'h000000B2, 1'b0, "wrap_b000");
        do_read(32'h001, F3_BU, 32'h000000A1, 1'b0, "wrap_b001");
        do_read(32'h3FE, F3_W,  32'hA1B2C3D4, 1'b0, "wrap_lw");
        do_read(32'h3FF, F3_H,  32'hFFFFB2C3, 1'b0, "wrap_lh");
        do_read(32'h10000010, F3_W, 32'hDEADBEEF, 1'b0, "alias_lw");

        do_reset_read(32'h10, "async_rst_lw_10");
        do_read(32'h3FE, F3_W, 32'h0, 1'b0, "post_rst_lw_3fe");

        // Write edge landing inside a reset pulse must leave memory cleared.
        do_write(32'h40, 32'h11223344, F3_W, 1'b1, "sw_40");
        @(posedge clk);
        #1;
        memWriteEnable = 1'b1;
        memAddr = 32'h44;
        memWriteData = 32'h55667788;
        func3 = F3_W;
        reset = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b1;
        memWriteEnable = 1'b0;
        do_read(32'h44, F3_W, 32'h0, 1'b0, "rst_beats_write");
        do_read(32'h40, F3_W, 32'h0, 1'b0, "rst_cleared_40");

        for (int it = 0; it < 400; it++) begin
            rhi = $urandom();
            ra = (($urandom_range(0, 1) == 0) ? 32'(($urandom_range(0, 63)))
                                              : 32'(($urandom_range(1000, 1023))));
            ra = ra | (rhi & 32'hFFFFFC00);
            rd = $urandom();
            rf = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) begin
                do_write(ra, rd, rf, ($urandom_range(0, 3) != 0), "rand_write");
            end else begin
                do_read(ra, rf, 32'h0, 1'b1, "rand_read");
            end
        end

        do_reset_read(32'h3FC, "async_rst_final");

        @(posedge clk);
        @(negedge clk);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover: %0d expectations left, required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
